// File: rtl/alu_regs_flags_if.sv
// Bus bundle between the sequencer and the A/B register + status stage.
// The sequencer (master) drives control, operand sources and the ALU result;
// the stage (slave) returns ALU operands, register contents, flags and pc_load.
interface alu_regs_flags_if #(
  parameter int W = 8
);
  logic         la;
  logic         lb;
  logic [1:0]   sa;
  logic [1:0]   sb;
  logic [W-1:0] lit;
  logic [W-1:0] mem_dout;
  logic [2:0]   alu_op;
  logic         flag_we;
  logic         jmp_en;
  logic [2:0]   jmp_cond;
  logic [W-1:0] alu_out;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [2:0]   alu_s;
  logic [W-1:0] reg_a;
  logic [W-1:0] reg_b;
  logic [3:0]   flags;
  logic         pc_load;

  modport master (
    output la, lb, sa, sb, lit, mem_dout, alu_op, flag_we, jmp_en, jmp_cond, alu_out,
    input  alu_a, alu_b, alu_s, reg_a, reg_b, flags, pc_load
  );

  modport slave (
    input  la, lb, sa, sb, lit, mem_dout, alu_op, flag_we, jmp_en, jmp_cond, alu_out,
    output alu_a, alu_b, alu_s, reg_a, reg_b, flags, pc_load
  );
endinterface

// File: rtl/alu_regs_flags.sv
// Register/status stage around the external combinational 8-bit ALU.
// Holds operand registers A and B, muxes ALU operands, writes ALU results back,
// captures {Z,N,C,V} on flag_we and resolves jump conditions from the
// registered flags so a compare in one cycle steers a jump in the next.
module alu_regs_flags #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  alu_regs_flags_if.slave bus
);

  localparam logic [2:0] OP_PASS = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_SHL  = 3'd6;
  localparam logic [2:0] OP_SHR  = 3'd7;

  localparam logic [2:0] JC_ALWAYS = 3'b000;
  localparam logic [2:0] JC_Z      = 3'b001;
  localparam logic [2:0] JC_NZ     = 3'b010;
  localparam logic [2:0] JC_GT     = 3'b011;
  localparam logic [2:0] JC_GE     = 3'b100;
  localparam logic [2:0] JC_N      = 3'b101;
  localparam logic [2:0] JC_LE     = 3'b110;
  localparam logic [2:0] JC_C      = 3'b111;

  logic [W-1:0] reg_a_q, reg_a_d;
  logic [W-1:0] reg_b_q, reg_b_d;
  logic [3:0]   flags_q, flags_d;

  logic [W-1:0] opa;
  logic [W-1:0] opb;
  logic [W:0]   add_full;
  logic         z_new, n_new, c_new, v_new;
  logic         flag_z, flag_n, flag_c;
  logic         cond_ok;

  // Operand a select: A, B or zero (both zero codes kept for decode symmetry).
  always_comb begin
    opa = '0;
    unique case (bus.sa)
      2'b00:   opa = reg_a_q;
      2'b10:   opa = reg_b_q;
      default: opa = '0;
    endcase
  end

  // Operand b select: B, instruction literal, memory read data or zero.
  always_comb begin
    opb = '0;
    unique case (bus.sb)
      2'b00:   opb = reg_b_q;
      2'b01:   opb = bus.lit;
      2'b10:   opb = bus.mem_dout;
      default: opb = '0;
    endcase
  end

  assign bus.alu_a = opa;
  assign bus.alu_b = opb;
  assign bus.alu_s = bus.alu_op;

  // Carry-out of the unsigned add is the top bit of a one-bit-wider sum.
  assign add_full = {1'b0, opa} + {1'b0, opb};

  // Flag candidates from this cycle's operands and the ALU result.
  always_comb begin
    z_new = (bus.alu_out == '0);
    n_new = bus.alu_out[W-1];
    c_new = 1'b0;
    v_new = 1'b0;
    unique case (bus.alu_op)
      OP_ADD: begin
        c_new = add_full[W];
        v_new = (opa[W-1] == opb[W-1]) && (bus.alu_out[W-1] != opa[W-1]);
      end
      OP_SUB: begin
        c_new = (opa < opb);
        v_new = (opa[W-1] != opb[W-1]) && (bus.alu_out[W-1] != opa[W-1]);
      end
      OP_SHL: c_new = opb[W-1];
      OP_SHR: c_new = opa[0];
      OP_PASS, OP_AND, OP_OR, OP_XOR: begin
        c_new = 1'b0;
        v_new = 1'b0;
      end
      default: begin
        c_new = 1'b0;
        v_new = 1'b0;
      end
    endcase
  end

  // Next-state for registers and flags; both writes read pre-edge values.
  always_comb begin
    reg_a_d = reg_a_q;
    reg_b_d = reg_b_q;
    flags_d = flags_q;
    if (bus.la)      reg_a_d = bus.alu_out;
    if (bus.lb)      reg_b_d = bus.alu_out;
    if (bus.flag_we) flags_d = {z_new, n_new, c_new, v_new};
  end

  // State update; reset wins over any pending load or flag capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_a_q <= '0;
      reg_b_q <= '0;
      flags_q <= 4'b0000;
    end else begin
      reg_a_q <= reg_a_d;
      reg_b_q <= reg_b_d;
      flags_q <= flags_d;
    end
  end

  assign flag_z = flags_q[3];
  assign flag_n = flags_q[2];
  assign flag_c = flags_q[1];

  // Jump condition decode from the registered flags only.
  always_comb begin
    cond_ok = 1'b0;
    unique case (bus.jmp_cond)
      JC_ALWAYS: cond_ok = 1'b1;
      JC_Z:      cond_ok = flag_z;
      JC_NZ:     cond_ok = !flag_z;
      JC_GT:     cond_ok = !flag_n && !flag_z;
      JC_GE:     cond_ok = !flag_n;
      JC_N:      cond_ok = flag_n;
      JC_LE:     cond_ok = flag_n || flag_z;
      JC_C:      cond_ok = flag_c;
      default:   cond_ok = 1'b0;
    endcase
  end

  assign bus.pc_load = bus.jmp_en && cond_ok;
  assign bus.reg_a   = reg_a_q;
  assign bus.reg_b   = reg_b_q;
  assign bus.flags   = flags_q;

endmodule

// File: tb/tb_alu_regs_flags.sv
module tb_alu_regs_flags;

  localparam logic [2:0] PASS = 3'd0, ADD = 3'd1, SUB = 3'd2, AND_ = 3'd3,
                         OR_ = 3'd4, XOR_ = 3'd5, SHL = 3'd6, SHR = 3'd7;

  typedef struct {
    logic       la, lb;
    logic [1:0] sa, sb;
    logic [7:0] lit, mem;
    logic [2:0] op;
    logic       fwe, jen;
    logic [2:0] jc;
    logic       exp_pc;
    logic [7:0] exp_a, exp_b;
    logic [3:0] exp_f;
  } vec_t;

  typedef struct {
    logic [7:0] a, b;
    logic [3:0] f;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  vec_t vecs[$];
  exp_t exp_q[$];
  logic [7:0] m_a, m_b;
  logic [3:0] m_f;

  alu_regs_flags_if #(.W(8)) bus ();
  alu_regs_flags #(.W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      PASS:    return b;
      ADD:     return a + b;
      SUB:     return a - b;
      AND_:    return a & b;
      OR_:     return a | b;
      XOR_:    return a ^ b;
      SHL:     return {b[6:0], 1'b0};
      default: return {1'b0, a[7:1]};
    endcase
  endfunction

  // external ALU
  always_comb bus.alu_out = alu_f(bus.alu_s, bus.alu_a, bus.alu_b);

  function automatic logic [3:0] flags_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    int ia, ib, sa_i, sb_i, s;
    logic c, v;
    r = alu_f(op, a, b);
    ia = int'(a); ib = int'(b);
    sa_i = a[7] ? ia - 256 : ia;
    sb_i = b[7] ? ib - 256 : ib;
    c = 1'b0; v = 1'b0;
    if (op == ADD) begin
      c = (ia + ib) > 255;
      s = sa_i + sb_i;
      v = (s > 127) || (s < -128);
    end else if (op == SUB) begin
      c = ia < ib;
      s = sa_i - sb_i;
      v = (s > 127) || (s < -128);
    end else if (op == SHL) c = b[7];
    else if (op == SHR) c = a[0];
    return {(r == 8'h00), r[7], c, v};
  endfunction

  function automatic logic cond_f(input logic jen, input logic [2:0] jc, input logic [3:0] f);
    logic z, n;
    z = f[3]; n = f[2];
    if (!jen) return 1'b0;
    case (jc)
      3'b000:  return 1'b1;
      3'b001:  return z;
      3'b010:  return !z;
      3'b011:  return !n && !z;
      3'b100:  return !n;
      3'b101:  return n;
      3'b110:  return n || z;
      default: return f[1];
    endcase
  endfunction

  function automatic vec_t mk(input logic la, input logic lb, input logic [1:0] sa, input logic [1:0] sb,
                              input logic [7:0] lit, input logic [7:0] mem, input logic [2:0] op,
                              input logic fwe, input logic jen, input logic [2:0] jc, input logic exp_pc,
                              input logic [7:0] ea, input logic [7:0] eb, input logic [3:0] ef);
    vec_t v;
    v.la = la; v.lb = lb; v.sa = sa; v.sb = sb; v.lit = lit; v.mem = mem; v.op = op;
    v.fwe = fwe; v.jen = jen; v.jc = jc; v.exp_pc = exp_pc;
    v.exp_a = ea; v.exp_b = eb; v.exp_f = ef;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic drive_idle();
    bus.la = 0; bus.lb = 0; bus.sa = 2'b01; bus.sb = 2'b11; bus.lit = 0; bus.mem_dout = 0;
    bus.alu_op = PASS; bus.flag_we = 0; bus.jmp_en = 0; bus.jmp_cond = 0;
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic apply(input vec_t v, input string tag);
    exp_t e, got;
    bus.la = v.la; bus.lb = v.lb; bus.sa = v.sa; bus.sb = v.sb; bus.lit = v.lit;
    bus.mem_dout = v.mem; bus.alu_op = v.op; bus.flag_we = v.fwe;
    bus.jmp_en = v.jen; bus.jmp_cond = v.jc;
    e.a = v.exp_a; e.b = v.exp_b; e.f = v.exp_f;
    exp_q.push_back(e);
    #1;
    chk({tag, " pc_load"}, 32'(bus.pc_load), 32'(v.exp_pc));
    chk({tag, " alu_s"}, 32'(bus.alu_s), 32'(v.op));
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    chk({tag, " reg_a"}, 32'(bus.reg_a), 32'(got.a));
    chk({tag, " reg_b"}, 32'(bus.reg_b), 32'(got.b));
    chk({tag, " flags"}, 32'(bus.flags), 32'(got.f));
    m_a = v.exp_a; m_b = v.exp_b; m_f = v.exp_f;
  endtask

  initial begin
    vec_t v;
    logic [7:0] oa, ob, r;
    drive_idle();
    //          la lb sa    sb    lit    mem    op   fwe jen jc pc  A      B      F
    vecs.push_back(mk(1, 0, 2'd1, 2'd1, 8'hFF, 8'h00, ADD, 0, 0, 3'd0, 0, 8'hFF, 8'h00, 4'b0000));
    vecs.push_back(mk(0, 1, 2'd1, 2'd1, 8'h01, 8'h00, ADD, 0, 1, 3'd0, 1, 8'hFF, 8'h01, 4'b0000));
    vecs.push_back(mk(1, 0, 2'd0, 2'd0, 8'h00, 8'h00, ADD, 1, 1, 3'd1, 0, 8'h00, 8'h01, 4'b1010));
    vecs.push_back(mk(1, 0, 2'd1, 2'd1, 8'h80, 8'h00, ADD, 0, 1, 3'd1, 1, 8'h80, 8'h01, 4'b1010));
    vecs.push_back(mk(1, 0, 2'd0, 2'd1, 8'h01, 8'h00, SUB, 1, 1, 3'd2, 0, 8'h7F, 8'h01, 4'b0001));
    vecs.push_back(mk(1, 0, 2'd1, 2'd1, 8'h05, 8'h00, ADD, 0, 1, 3'd2, 1, 8'h05, 8'h01, 4'b0001));
    vecs.push_back(mk(0, 1, 2'd1, 2'd1, 8'h07, 8'h00, ADD, 0, 0, 3'd0, 0, 8'h05, 8'h07, 4'b0001));
    vecs.push_back(mk(0, 0, 2'd0, 2'd0, 8'h00, 8'h00, SUB, 1, 1, 3'd3, 1, 8'h05, 8'h07, 4'b0110));
    vecs.push_back(mk(0, 0, 2'd0, 2'd0, 8'h00, 8'h00, PASS, 0, 1, 3'd5, 1, 8'h05, 8'h07, 4'b0110));
    vecs.push_back(mk(0, 0, 2'd0, 2'd0, 8'h00, 8'h00, PASS, 0, 1, 3'd4, 0, 8'h05, 8'h07, 4'b0110));
    vecs.push_back(mk(0, 0, 2'd0, 2'd0, 8'h00, 8'h00, PASS, 0, 1, 3'd7, 1, 8'h05, 8'h07, 4'b0110));
    vecs.push_back(mk(0, 1, 2'd1, 2'd1, 8'h81, 8'h00, ADD, 0, 1, 3'd6, 1, 8'h05, 8'h81, 4'b0110));
    vecs.push_back(mk(0, 1, 2'd0, 2'd0, 8'h00, 8'h00, SHL, 1, 0, 3'd0, 0, 8'h05, 8'h02, 4'b0010));
    vecs.push_back(mk(1, 0, 2'd1, 2'd1, 8'h01, 8'h00, ADD, 0, 1, 3'd7, 1, 8'h01, 8'h02, 4'b0010));
    vecs.push_back(mk(1, 0, 2'd0, 2'd0, 8'h00, 8'h00, SHR, 1, 1, 3'd6, 0, 8'h00, 8'h02, 4'b1010));
    vecs.push_back(mk(1, 1, 2'd1, 2'd2, 8'h00, 8'h3C, ADD, 0, 1, 3'd1, 1, 8'h3C, 8'h3C, 4'b1010));
    vecs.push_back(mk(0, 0, 2'd0, 2'd0, 8'h00, 8'h00, PASS, 0, 0, 3'd0, 0, 8'h3C, 8'h3C, 4'b1010));

    // power-on reset
    #1 rst = 1'b1;
    #1;
    chk("por reg_a", 32'(bus.reg_a), 32'h0);
    chk("por reg_b", 32'(bus.reg_b), 32'h0);
    chk("por flags", 32'(bus.flags), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // reset pulse mid-cycle with every write enable pending
    bus.la = 1; bus.lb = 1; bus.flag_we = 1; bus.sa = 2'b01; bus.sb = 2'b01;
    bus.lit = 8'h55; bus.alu_op = ADD; bus.jmp_en = 1; bus.jmp_cond = 3'b001;
    #2 rst = 1'b1;
    #1;
    chk("rst reg_a", 32'(bus.reg_a), 32'h0);
    chk("rst reg_b", 32'(bus.reg_b), 32'h0);
    chk("rst flags", 32'(bus.flags), 32'h0);
    chk("rst pc_load z", 32'(bus.pc_load), 32'h0);
    bus.jmp_cond = 3'b000;
    #1;
    chk("rst pc_load always", 32'(bus.pc_load), 32'h1);
    @(posedge clk);
    #1;
    chk("rst held reg_a", 32'(bus.reg_a), 32'h0);
    chk("rst held flags", 32'(bus.flags), 32'h0);
    #3;
    drive_idle();
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post rst reg_a", 32'(bus.reg_a), 32'h0);
    chk("post rst reg_b", 32'(bus.reg_b), 32'h0);
    chk("post rst flags", 32'(bus.flags), 32'h0);
    m_a = 0; m_b = 0; m_f = 0;

    // random traffic against the bench model
    for (int k = 0; k < 60; k++) begin
      v.la = 1'($urandom_range(0, 1)); v.lb = 1'($urandom_range(0, 1));
      v.sa = 2'($urandom_range(0, 3)); v.sb = 2'($urandom_range(0, 3));
      v.lit = 8'($urandom_range(0, 255)); v.mem = 8'($urandom_range(0, 255));
      v.op = 3'($urandom_range(0, 7)); v.fwe = 1'($urandom_range(0, 1));
      v.jen = 1'($urandom_range(0, 1)); v.jc = 3'($urandom_range(0, 7));
      oa = (v.sa == 2'd0) ? m_a : (v.sa == 2'd2) ? m_b : 8'h00;
      ob = (v.sb == 2'd0) ? m_b : (v.sb == 2'd1) ? v.lit : (v.sb == 2'd2) ? v.mem : 8'h00;
      r = alu_f(v.op, oa, ob);
      v.exp_pc = cond_f(v.jen, v.jc, m_f);
      v.exp_a = v.la ? r : m_a;
      v.exp_b = v.lb ? r : m_b;
      v.exp_f = v.fwe ? flags_f(v.op, oa, ob) : m_f;
      apply(v, $sformatf("rnd%0d", k));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
